// File: rtl/mailbox_producer_ctrl_if.sv
// Port-A BRAM, upstream FIFO head and status signals of the mailbox producer.
// The controller drives the BRAM port and FIFO pop (master); the environment drives the rest.
interface mailbox_producer_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [8:0]       bram_douta;
  logic             bram_wea;
  logic [1:0]       bram_addra;
  logic [8:0]       bram_dina;
  logic [7:0]       data_in;
  logic             data_in_valid;
  logic             data_in_ready;
  logic             req_pending;
  logic             overrun_err;
  logic [CNT_W-1:0] words_sent;

  modport master (
    input  bram_douta, data_in, data_in_valid,
    output bram_wea, bram_addra, bram_dina, data_in_ready,
    output req_pending, overrun_err, words_sent
  );

  modport slave (
    output bram_douta, data_in, data_in_valid,
    input  bram_wea, bram_addra, bram_dina, data_in_ready,
    input  req_pending, overrun_err, words_sent
  );
endinterface

// File: rtl/mailbox_producer_ctrl.sv
// Port-A sequencer for the 4-word BRAM mailbox: polls frame_ready (addr0), publishes FIFO
// availability (addr1) and, once per frame_ready rising edge, pops one byte into addr2 with a flipped toggle.
module mailbox_producer_ctrl #(
  parameter int READ_LATENCY = 2,
  parameter int CNT_W        = 16
) (
  input  logic clk_100mhz,
  input  logic rst,
  mailbox_producer_ctrl_if.master mbx
);

  typedef enum logic [2:0] {
    S_POLL,
    S_WAIT,
    S_EVAL,
    S_WR_FIFO,
    S_WR_DATA
  } state_e;

  localparam logic [1:0] WAIT_LAST = 2'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

  state_e           state_q, state_d;
  logic [1:0]       wait_cnt_q, wait_cnt_d;
  logic             prev_fr_q, prev_fr_d;
  logic             toggle_q, toggle_d;
  logic             req_q, req_d;
  logic             ovr_q, ovr_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic             wea_q, wea_d;
  logic [1:0]       addra_q, addra_d;
  logic [8:0]       dina_q, dina_d;
  logic             rdy_q, rdy_d;

  logic fr;
  logic unused_douta;

  assign fr           = mbx.bram_douta[0];
  assign unused_douta = ^mbx.bram_douta[8:1];

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state_q    <= S_POLL;
      wait_cnt_q <= 2'd0;
      prev_fr_q  <= 1'b0;
      toggle_q   <= 1'b0;
      req_q      <= 1'b0;
      ovr_q      <= 1'b0;
      words_q    <= '0;
      wea_q      <= 1'b0;
      addra_q    <= 2'd0;
      dina_q     <= 9'd0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      prev_fr_q  <= prev_fr_d;
      toggle_q   <= toggle_d;
      req_q      <= req_d;
      ovr_q      <= ovr_d;
      words_q    <= words_d;
      wea_q      <= wea_d;
      addra_q    <= addra_d;
      dina_q     <= dina_d;
      rdy_q      <= rdy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    prev_fr_d  = prev_fr_q;
    toggle_d   = toggle_q;
    req_d      = req_q;
    ovr_d      = ovr_q;
    words_d    = words_q;

    case (state_q)
      S_POLL: begin
        wait_cnt_d = 2'd0;
        state_d    = (READ_LATENCY > 1) ? S_WAIT : S_EVAL;
      end
      S_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) state_d = S_EVAL;
        else                         wait_cnt_d = wait_cnt_q + 2'd1;
      end
      S_EVAL: begin
        prev_fr_d = fr;
        // Only rising edges of frame_ready count as requests.
        if (fr && !prev_fr_q) begin
          if (req_q) ovr_d = 1'b1;
          else       req_d = 1'b1;
        end
        state_d = S_WR_FIFO;
      end
      S_WR_FIFO: begin
        state_d = (req_q && mbx.data_in_valid) ? S_WR_DATA : S_POLL;
      end
      S_WR_DATA: begin
        toggle_d = ~toggle_q;
        req_d    = 1'b0;
        words_d  = words_q + CNT_W'(1);
        state_d  = S_POLL;
      end
      default: state_d = S_POLL;
    endcase
  end

  // Port outputs are decoded from the next state so the registers match the state they accompany.
  always_comb begin
    wea_d   = 1'b0;
    addra_d = 2'd0;
    dina_d  = 9'd0;
    rdy_d   = 1'b0;
    case (state_d)
      S_WR_FIFO: begin
        wea_d   = 1'b1;
        addra_d = 2'd1;
        dina_d  = {8'h00, mbx.data_in_valid};
      end
      S_WR_DATA: begin
        wea_d   = 1'b1;
        addra_d = 2'd2;
        dina_d  = {mbx.data_in, ~toggle_q};
        rdy_d   = 1'b1;
      end
      default: ;
    endcase
  end

  assign mbx.bram_wea      = wea_q;
  assign mbx.bram_addra    = addra_q;
  assign mbx.bram_dina     = dina_q;
  assign mbx.data_in_ready = rdy_q;
  assign mbx.req_pending   = req_q;
  assign mbx.overrun_err   = ovr_q;
  assign mbx.words_sent    = words_q;

endmodule
